// File: rtl/hovalaag_pkg.sv
// Shared constants for the Hovalaag input queue.
// Word width and channel encodings used by the host demux.
package hovalaag_pkg;
  localparam int HV_WORD_W = 12;
  localparam int HV_DEPTH  = 16;
  localparam logic CH_IN1 = 1'b0;
  localparam logic CH_IN2 = 1'b1;
endpackage

// File: rtl/hovalaag_in_queue_if.sv
// Host-side valid/ready push channel into the queue.
// master = host logic, slave = queue.
import hovalaag_pkg::*;

interface hovalaag_in_queue_if #(
  parameter int WIDTH = HV_WORD_W
);
  logic [WIDTH-1:0] host_data;
  logic             host_sel;
  logic             host_valid;
  logic             host_ready;

  modport master (
    output host_data,
    output host_sel,
    output host_valid,
    input  host_ready
  );

  modport slave (
    input  host_data,
    input  host_sel,
    input  host_valid,
    output host_ready
  );
endinterface

// File: rtl/hovalaag_sfifo.sv
// Single-clock FIFO with occupancy count and sync flush.
// Memory is unreset; empty masking happens one level up.
module hovalaag_sfifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CW'(DEPTH));
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/hovalaag_in_queue.sv
// Dual input queue feeding the Hovalaag core IN1/IN2 ports.
// Host words are demuxed by channel; core advances pop the heads.
import hovalaag_pkg::*;

module hovalaag_in_queue #(
  parameter int WIDTH = HV_WORD_W,
  parameter int DEPTH = HV_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  hovalaag_in_queue_if.slave         host,
  output logic [WIDTH-1:0]           IN1,
  input  logic                       IN1_adv,
  output logic [WIDTH-1:0]           IN2,
  input  logic                       IN2_adv,
  output logic [$clog2(DEPTH+1)-1:0] in1_count,
  output logic [$clog2(DEPTH+1)-1:0] in2_count,
  output logic                       in1_empty,
  output logic                       in2_empty,
  output logic [1:0]                 underflow
);
  logic [WIDTH-1:0] w_rdata0;
  logic [WIDTH-1:0] w_rdata1;
  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic             w_acc;
  logic [1:0]       r_uflow;

  assign host.host_ready = ~rst & ~flush & ~w_full[host.host_sel];
  assign w_acc = host.host_valid & host.host_ready;

  always_comb begin
    w_push = '0;
    unique case (host.host_sel)
      CH_IN1:  w_push[0] = w_acc;
      CH_IN2:  w_push[1] = w_acc;
      default: w_push = '0;
    endcase
  end

  hovalaag_sfifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ch0 (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (w_push[0]),
    .pop  (IN1_adv),
    .wdata(host.host_data),
    .rdata(w_rdata0),
    .count(in1_count),
    .empty(w_empty[0]),
    .full (w_full[0])
  );

  hovalaag_sfifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (w_push[1]),
    .pop  (IN2_adv),
    .wdata(host.host_data),
    .rdata(w_rdata1),
    .count(in2_count),
    .empty(w_empty[1]),
    .full (w_full[1])
  );

  // Stale memory behind an empty FIFO must never reach the core.
  assign IN1 = w_empty[0] ? '0 : w_rdata0;
  assign IN2 = w_empty[1] ? '0 : w_rdata1;

  assign in1_empty = w_empty[0];
  assign in2_empty = w_empty[1];
  assign underflow = r_uflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_uflow <= '0;
    else if (flush)
      r_uflow <= '0;
    else
      r_uflow <= r_uflow |
        {IN2_adv & w_empty[1], IN1_adv & w_empty[0]};
  end
endmodule

// File: tb/tb_hovalaag_in_queue.sv
// Directed bench for hovalaag_in_queue.
// Queue scoreboard per channel predicts heads, counts and flags.
module tb_hovalaag_in_queue;
  localparam int W = 12;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         IN1_adv = 1'b0;
  logic         IN2_adv = 1'b0;
  logic [W-1:0] IN1;
  logic [W-1:0] IN2;
  logic [4:0]   in1_count;
  logic [4:0]   in2_count;
  logic         in1_empty;
  logic         in2_empty;
  logic [1:0]   underflow;

  hovalaag_in_queue_if #(.WIDTH(W)) host ();

  hovalaag_in_queue #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .host     (host),
    .IN1      (IN1),
    .IN1_adv  (IN1_adv),
    .IN2      (IN2),
    .IN2_adv  (IN2_adv),
    .in1_count(in1_count),
    .in2_count(in2_count),
    .in1_empty(in1_empty),
    .in2_empty(in2_empty),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [1:0]   uf_m = 2'b00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    chk({tag, ".IN1"}, 32'(IN1), 32'(h0));
    chk({tag, ".IN2"}, 32'(IN2), 32'(h1));
    chk({tag, ".in1_count"}, 32'(in1_count), q0.size());
    chk({tag, ".in2_count"}, 32'(in2_count), q1.size());
    chk({tag, ".in1_empty"}, 32'(in1_empty), 32'(q0.size() == 0));
    chk({tag, ".in2_empty"}, 32'(in2_empty), 32'(q1.size() == 0));
    chk({tag, ".underflow"}, 32'(underflow), 32'(uf_m));
  endtask

  task automatic cycle(input string tag,
                       input logic v, input logic s,
                       input logic [W-1:0] d,
                       input logic a1, input logic a2,
                       input logic fl);
    logic rdy_m;
    logic p0;
    logic p1;
    host.host_valid = v;
    host.host_sel   = s;
    host.host_data  = d;
    IN1_adv = a1;
    IN2_adv = a2;
    flush   = fl;
    #1;
    rdy_m = !rst && !fl &&
      ((s ? q1.size() : q0.size()) < D);
    chk({tag, ".host_ready"}, 32'(host.host_ready), 32'(rdy_m));
    @(posedge clk);
    #1;
    if (fl) begin
      q0.delete();
      q1.delete();
      uf_m = 2'b00;
    end else begin
      p0 = a1 && (q0.size() > 0);
      p1 = a2 && (q1.size() > 0);
      if (a1 && q0.size() == 0) uf_m[0] = 1'b1;
      if (a2 && q1.size() == 0) uf_m[1] = 1'b1;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (v && rdy_m) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
    check_outs(tag);
    host.host_valid = 1'b0;
    IN1_adv = 1'b0;
    IN2_adv = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    host.host_valid = 1'b0;
    host.host_sel   = 1'b0;
    host.host_data  = '0;
    #3;
    chk("rst.host_ready", 32'(host.host_ready), 32'(0));
    check_outs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: two pushes to ch0, then one pop
    cycle("t1.push0", 1, 0, 12'h123, 0, 0, 0);
    chk("t1.head_first", 32'(IN1), 32'h123);
    cycle("t1.push1", 1, 0, 12'h456, 0, 0, 0);
    cycle("t1.pop", 0, 0, 12'h000, 1, 0, 0);
    chk("t1.head_next", 32'(IN1), 32'h456);
    chk("t1.count", 32'(in1_count), 32'd1);

    // 2: fill ch1, ready per selected channel
    for (int i = 0; i < D; i++)
      cycle("t2.fill", 1, 1, W'(12'h200 + i), 0, 0, 0);
    chk("t2.count_full", 32'(in2_count), 32'd16);
    cycle("t2.rdy_sel1", 0, 1, 12'h000, 0, 0, 0);
    cycle("t2.rdy_sel0", 0, 0, 12'h000, 0, 0, 0);
    cycle("t2.refused", 1, 1, 12'hEEE, 0, 0, 0);
    cycle("t2.pop", 0, 1, 12'h000, 0, 1, 0);
    cycle("t2.rdy_after", 0, 1, 12'h000, 0, 0, 0);
    chk("t2.ready_back", 32'(host.host_ready), 32'd1);

    // 3: full ch0 push+pop, then mid-level push+pop
    for (int i = 0; i < D - 1; i++)
      cycle("t3.fill", 1, 0, W'(12'h300 + i), 0, 0, 0);
    chk("t3.full", 32'(in1_count), 32'd16);
    cycle("t3.full_pp", 1, 0, 12'hAAA, 1, 0, 0);
    chk("t3.count15", 32'(in1_count), 32'd15);
    for (int i = 0; i < 10; i++)
      cycle("t3.drain", 0, 0, 12'h000, 1, 0, 0);
    cycle("t3.mid_pp", 1, 0, 12'hBBB, 1, 0, 0);
    chk("t3.count5", 32'(in1_count), 32'd5);
    cycle("t3.flush", 1, 0, 12'hCCC, 1, 1, 1);

    // 4: underflow on ch1, cleared by flush
    cycle("t4.uf", 0, 1, 12'h000, 0, 1, 0);
    chk("t4.uf_bits", 32'(underflow), 32'h2);
    cycle("t4.uf_push", 1, 0, 12'h0F0, 1, 0, 0);
    cycle("t4.flush", 0, 0, 12'h000, 0, 0, 1);
    chk("t4.uf_clear", 32'(underflow), 32'h0);

    // 5: streaming push/pop on ch0 across pointer wrap
    cycle("t5.seed", 1, 0, 12'd0, 0, 0, 0);
    for (int i = 1; i < 40; i++)
      cycle("t5.stream", 1, 0, W'(i), 1, 0, 0);
    cycle("t5.last", 0, 0, 12'h000, 1, 0, 0);

    // 6: async reset mid-stream
    cycle("t6.ld0", 1, 0, 12'h611, 0, 0, 0);
    cycle("t6.ld1", 1, 1, 12'h622, 0, 0, 0);
    cycle("t6.ld2", 1, 0, 12'h633, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    uf_m = 2'b00;
    check_outs("t6.async");
    chk("t6.host_ready", 32'(host.host_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle("t6.post", 1, 1, 12'h777, 0, 0, 0);
    cycle("t6.postpop", 0, 0, 12'h000, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
